blackjack_round_ctrl: RTL and testbench

//  Single-round blackjack sequencer. Drives the card generator's `on` strobe, captures the two card

---
 rtl/blackjack_round_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : blackjack_round_ctrl
//  Description : Single-round blackjack sequencer. Requests cards from the
//                card generator, tracks player and dealer hands with soft-ace
//                totals, runs the player hit/stand phase and the dealer
//                draw-to-threshold phase, then reports the round outcome.
//  Config      : BJ_DOUBLE_EN - when defined, enables the double-down action.
//  Revision    : 1.0 - initial release
// ============================================================================
module blackjack_round_ctrl #(
    parameter int DEALER_STAND = 17,
    parameter int BJ_TOTAL     = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic       dbl,
    input  logic [3:0] card1_in,
    input  logic [3:0] card2_in,
    output logic       card_on,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       blackjack,
    output logic       doubled
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_P_REQ   = 4'd1,
        S_P_WAIT  = 4'd2,
        S_D_REQ   = 4'd3,
        S_D_WAIT  = 4'd4,
        S_PLAYER  = 4'd5,
        S_H_REQ   = 4'd6,
        S_H_WAIT  = 4'd7,
        S_DEALER  = 4'd8,
        S_DH_REQ  = 4'd9,
        S_DH_WAIT = 4'd10,
        S_RESOLVE = 4'd11,
        S_DONE    = 4'd12
    } state_t;

    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;
    localparam logic [1:0] RES_PUSH   = 2'b11;
    localparam logic [4:0] LIM_BJ     = 5'(BJ_TOTAL);
    localparam logic [4:0] LIM_STAND  = 5'(DEALER_STAND);

    // Defensive clamp: the generator never returns more than 10.
    function automatic logic [3:0] clamp_card(input logic [3:0] c);
        return (c > 4'd10) ? 4'd10 : c;
    endfunction

    // Hard total accumulation, saturating at 31.
    function automatic logic [4:0] add_sat(input logic [4:0] h, input logic [3:0] c);
        logic [5:0] s;
        s = {1'b0, h} + {2'b00, c};
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    // Best total: count one ace as 11 when that does not bust the hand.
    function automatic logic [4:0] best_of(input logic [4:0] h, input logic a);
        logic [5:0] s;
        s = {1'b0, h} + 6'd10;
        return (a && (s <= {1'b0, LIM_BJ})) ? s[4:0] : h;
    endfunction

    state_t     state_q, state_d;
    logic [4:0] p_hard_q, p_hard_d;
    logic       p_ace_q, p_ace_d;
    logic [1:0] p_cnt_q, p_cnt_d;
    logic [4:0] d_hard_q, d_hard_d;
    logic       d_ace_q, d_ace_d;
    logic [3:0] d_up_q, d_up_d;
    logic [1:0] result_q, result_d;
    logic       bj_q, bj_d;
    logic       dbl_q, dbl_d;

    logic [3:0] card1_c, card2_c;
    logic [4:0] p_best, d_best, up_best, hit_hard, hit_best;
    logic       hit_ace, reveal;

    assign card1_c  = clamp_card(card1_in);
    assign card2_c  = clamp_card(card2_in);
    assign p_best   = best_of(p_hard_q, p_ace_q);
    assign d_best   = best_of(d_hard_q, d_ace_q);
    assign up_best  = best_of({1'b0, d_up_q}, d_up_q == 4'd1);
    assign hit_hard = add_sat(p_hard_q, card1_c);
    assign hit_ace  = p_ace_q | (card1_c == 4'd1);
    assign hit_best = best_of(hit_hard, hit_ace);

    // Round sequencing, hand updates and state-decoded outputs.
    always_comb begin
        state_d  = state_q;
        p_hard_d = p_hard_q;
        p_ace_d  = p_ace_q;
        p_cnt_d  = p_cnt_q;
        d_hard_d = d_hard_q;
        d_ace_d  = d_ace_q;
        d_up_d   = d_up_q;
        result_d = result_q;
        bj_d     = bj_q;
        dbl_d    = dbl_q;
        card_on  = 1'b0;
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = (state_q == S_DONE);
        reveal   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_P_REQ;
                    p_hard_d = 5'd0;
                    p_ace_d  = 1'b0;
                    p_cnt_d  = 2'd0;
                    d_hard_d = 5'd0;
                    d_ace_d  = 1'b0;
                    d_up_d   = 4'd0;
                    result_d = 2'b00;
                    bj_d     = 1'b0;
                    dbl_d    = 1'b0;
                end
                reveal = (state_q == S_DONE);
            end
            S_P_REQ: begin
                card_on = ~reset;
                state_d = S_P_WAIT;
            end
            S_P_WAIT: begin
                if ((card1_c != 4'd0) && (card2_c != 4'd0)) begin
                    p_hard_d = {1'b0, card1_c} + {1'b0, card2_c};
                    p_ace_d  = (card1_c == 4'd1) || (card2_c == 4'd1);
                    p_cnt_d  = 2'd2;
                    state_d  = S_D_REQ;
                end else begin
                    state_d = S_P_REQ;
                end
            end
            S_D_REQ: begin
                card_on = ~reset;
                state_d = S_D_WAIT;
            end
            S_D_WAIT: begin
                if ((card1_c != 4'd0) && (card2_c != 4'd0)) begin
                    d_up_d   = card1_c;
                    d_hard_d = {1'b0, card1_c} + {1'b0, card2_c};
                    d_ace_d  = (card1_c == 4'd1) || (card2_c == 4'd1);
                    if (p_best == LIM_BJ) begin
                        bj_d    = 1'b1;
                        state_d = S_RESOLVE;
                    end else begin
                        state_d = S_PLAYER;
                    end
                end else begin
                    state_d = S_D_REQ;
                end
            end
            S_PLAYER: begin
                // Stand outranks double, which outranks hit.
                if (stand) begin
                    state_d = S_DEALER;
                end
`ifdef BJ_DOUBLE_EN
                else if (dbl && (p_cnt_q == 2'd2)) begin
                    dbl_d   = 1'b1;
                    state_d = S_H_REQ;
                end
`endif
                else if (hit) begin
                    state_d = S_H_REQ;
                end
            end
            S_H_REQ: begin
                card_on = ~reset;
                state_d = S_H_WAIT;
            end
            S_H_WAIT: begin
                if (card1_c != 4'd0) begin
                    p_hard_d = hit_hard;
                    p_ace_d  = hit_ace;
                    p_cnt_d  = (p_cnt_q == 2'd3) ? 2'd3 : p_cnt_q + 2'd1;
                    if (hit_hard > LIM_BJ) begin
                        state_d = S_RESOLVE;
                    end else if (dbl_q || (hit_best == LIM_BJ)) begin
                        state_d = S_DEALER;
                    end else begin
                        state_d = S_PLAYER;
                    end
                end else begin
                    state_d = S_H_REQ;
                end
            end
            S_DEALER: begin
                reveal = 1'b1;
                // A soft total at the threshold stands.
                if ((d_hard_q > LIM_BJ) || (d_best >= LIM_STAND)) begin
                    state_d = S_RESOLVE;
                end else begin
                    state_d = S_DH_REQ;
                end
            end
            S_DH_REQ: begin
                reveal  = 1'b1;
                card_on = ~reset;
                state_d = S_DH_WAIT;
            end
            S_DH_WAIT: begin
                reveal = 1'b1;
                if (card1_c != 4'd0) begin
                    d_hard_d = add_sat(d_hard_q, card1_c);
                    d_ace_d  = d_ace_q | (card1_c == 4'd1);
                    state_d  = S_DEALER;
                end else begin
                    state_d = S_DH_REQ;
                end
            end
            S_RESOLVE: begin
                reveal = 1'b1;
                if (p_hard_q > LIM_BJ) begin
                    result_d = RES_DEALER;
                end else if (bj_q) begin
                    // Only the dealt two cards exist here, so 21 is a natural.
                    result_d = (d_best == LIM_BJ) ? RES_PUSH : RES_PLAYER;
                end else if (d_hard_q > LIM_BJ) begin
                    result_d = RES_PLAYER;
                end else if (p_best > d_best) begin
                    result_d = RES_PLAYER;
                end else if (p_best < d_best) begin
                    result_d = RES_DEALER;
                end else begin
                    result_d = RES_PUSH;
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and hand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            p_hard_q <= 5'd0;
            p_ace_q  <= 1'b0;
            p_cnt_q  <= 2'd0;
            d_hard_q <= 5'd0;
            d_ace_q  <= 1'b0;
            d_up_q   <= 4'd0;
            result_q <= 2'b00;
            bj_q     <= 1'b0;
            dbl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_hard_q <= p_hard_d;
            p_ace_q  <= p_ace_d;
            p_cnt_q  <= p_cnt_d;
            d_hard_q <= d_hard_d;
            d_ace_q  <= d_ace_d;
            d_up_q   <= d_up_d;
            result_q <= result_d;
            bj_q     <= bj_d;
            dbl_q    <= dbl_d;
        end
    end

    assign player_total = p_best;
    assign dealer_total = reveal ? d_best : up_best;
    assign result       = result_q;
    assign blackjack    = bj_q;

`ifdef BJ_DOUBLE_EN
    assign doubled = dbl_q;
`else
    // Without double-down the request input has no effect.
    assign doubled = 1'b0 & dbl;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blackjack_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blackjack_round_ctrl
//  Description : Self-checking bench for blackjack_round_ctrl. A card
//                generator model feeds directed cards; a rules-level model
//                predicts the final round outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blackjack_round_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, hit, stand, dbl;
    logic [3:0] card1_in, card2_in;
    logic       card_on;
    logic [4:0] player_total, dealer_total;
    logic       busy, done;
    logic [1:0] result;
    logic       blackjack, doubled;

    blackjack_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hit          (hit),
        .stand        (stand),
        .dbl          (dbl),
        .card1_in     (card1_in),
        .card2_in     (card2_in),
        .card_on      (card_on),
        .player_total (player_total),
        .dealer_total (dealer_total),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .blackjack    (blackjack),
        .doubled      (doubled)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Card generator: answers each strobe with the next queued pair.
    logic [3:0] gq1[$];
    logic [3:0] gq2[$];
    int         pulses = 0;

    always @(negedge clk) begin
        if (card_on) begin
            pulses = pulses + 1;
            if (gq1.size() > 0) begin
                card1_in = gq1.pop_front();
                card2_in = gq2.pop_front();
            end else begin
                card1_in = 4'd0;
                card2_in = 4'd0;
            end
        end
    end

    // Rules-level round model.
    int hit_cards[$];
    int draw_cards[$];
    int pt_at[8];
    int exp_pt, exp_dt, exp_res, exp_bj, exp_dbl, exp_up;
    int m_nat, m_nhit, m_ndraw, m_stand, m_pulses;
    bit chk_en = 1'b0;

    function automatic int best_of(input int hard, input bit ace);
        int h;
        h = (hard > 31) ? 31 : hard;
        return (ace && (h + 10 <= 21)) ? h + 10 : h;
    endfunction

    task automatic model(input int p1, input int p2, input int d1, input int d2, input int mode);
        int ph, dh, pb, db;
        bit pa, da;
        ph = p1 + p2;  pa = (p1 == 1) || (p2 == 1);
        dh = d1 + d2;  da = (d1 == 1) || (d2 == 1);
        exp_up  = best_of(d1, d1 == 1);
        m_nat   = (best_of(ph, pa) == 21) ? 1 : 0;
        m_nhit  = 0;
        m_ndraw = 0;
        exp_dbl = 0;
        if (m_nat == 0) begin
            if (mode == 2) begin
                pt_at[0] = best_of(ph, pa);
                ph = ph + hit_cards[0];
                pa = pa | (hit_cards[0] == 1);
                m_nhit = 1;
                exp_dbl = 1;
            end else begin
                foreach (hit_cards[i]) begin
                    if (ph > 21 || best_of(ph, pa) == 21) break;
                    pt_at[i] = best_of(ph, pa);
                    ph = ph + hit_cards[i];
                    pa = pa | (hit_cards[i] == 1);
                    m_nhit = m_nhit + 1;
                end
            end
        end
        pt_at[m_nhit] = best_of(ph, pa);
        m_stand = (m_nat == 0 && ph <= 21 && best_of(ph, pa) != 21 && mode != 2) ? 1 : 0;
        if (m_nat == 0 && ph <= 21) begin
            while (dh <= 21 && best_of(dh, da) < 17 && m_ndraw < draw_cards.size()) begin
                dh = dh + draw_cards[m_ndraw];
                da = da | (draw_cards[m_ndraw] == 1);
                m_ndraw = m_ndraw + 1;
            end
        end
        pb = best_of(ph, pa);
        db = best_of(dh, da);
        exp_pt = pb;
        exp_dt = db;
        exp_bj = m_nat;
        if (ph > 21)       exp_res = 2;
        else if (m_nat==1) exp_res = (db == 21) ? 3 : 1;
        else if (dh > 21)  exp_res = 1;
        else if (pb > db)  exp_res = 1;
        else if (pb < db)  exp_res = 2;
        else               exp_res = 3;
    endtask

    task automatic set_cards(input int h0, input int h1, input int h2, input int r0, input int r1);
        hit_cards.delete();
        draw_cards.delete();
        if (h0 != 0) hit_cards.push_back(h0);
        if (h1 != 0) hit_cards.push_back(h1);
        if (h2 != 0) hit_cards.push_back(h2);
        if (r0 != 0) draw_cards.push_back(r0);
        if (r1 != 0) draw_cards.push_back(r1);
    endtask

    task automatic push_pair(input int a, input int b);
        gq1.push_back(4'(a));
        gq2.push_back(4'(b));
    endtask

    // Outputs checked on every cycle the round result is on display.
    always @(negedge clk) begin
        if (chk_en && done) begin
            check("result",       int'(result),       exp_res);
            check("blackjack",    int'(blackjack),    exp_bj);
            check("player_total", int'(player_total), exp_pt);
            check("dealer_total", int'(dealer_total), exp_dt);
            check("doubled",      int'(doubled),      exp_dbl);
            check("busy_in_done", int'(busy),         0);
        end
    end

    // Returns once the DUT sits idle mid-round waiting for the player.
    task automatic wait_player();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 80) begin
            @(negedge clk);
            n = n + 1;
            if (busy && !done && !card_on) quiet = quiet + 1;
            else quiet = 0;
        end
        if (quiet < 4) check("player_wait_timeout", quiet, 4);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        check("round_done", int'(done), 1);
    endtask

    // mode: 0 hit/stand, 1 start + hit&stand together, 2 double, 3 dbl ignored
    task automatic run_round(input int p1, input int p2, input int d1, input int d2,
                             input int mode, input bit zero_deal, input bit zero_hit);
        model(p1, p2, d1, d2, mode);
        gq1.delete();
        gq2.delete();
        if (zero_deal) push_pair(7, 0);
        push_pair(p1, p2);
        push_pair(d1, d2);
        for (int i = 0; i < m_nhit; i++) begin
            if (zero_hit && i == 0) push_pair(0, 9);
            push_pair(hit_cards[i], 0);
        end
        for (int i = 0; i < m_ndraw; i++) push_pair(draw_cards[i], 0);
        m_pulses = gq1.size();
        chk_en = 1'b0;
        pulses = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_en = 1'b1;
        if (m_nat == 0) begin
            for (int i = 0; i < m_nhit; i++) begin
                wait_player();
                check("running_player", int'(player_total), pt_at[i]);
                check("dealer_upcard",  int'(dealer_total), exp_up);
                if (mode == 2) dbl = 1'b1; else hit = 1'b1;
                @(negedge clk);
                dbl = 1'b0;
                hit = 1'b0;
            end
            if (m_stand == 1) begin
                wait_player();
                check("stand_player", int'(player_total), pt_at[m_nhit]);
                check("dealer_upcard", int'(dealer_total), exp_up);
                if (mode == 3) begin
                    dbl = 1'b1;
                    @(negedge clk);
                    dbl = 1'b0;
                    wait_player();
                    check("dbl_ignored_total", int'(player_total), pt_at[m_nhit]);
                    check("dbl_ignored_flag",  int'(doubled), 0);
                end
                if (mode == 1) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    wait_player();
                    check("start_ignored_total", int'(player_total), pt_at[m_nhit]);
                    hit = 1'b1;
                    stand = 1'b1;
                    @(negedge clk);
                    hit = 1'b0;
                    stand = 1'b0;
                end else begin
                    stand = 1'b1;
                    @(negedge clk);
                    stand = 1'b0;
                end
            end
        end
        wait_done();
        check("card_on_pulses", pulses, m_pulses);
        check("cards_left", gq1.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0; dbl = 1'b0;
        card1_in = 4'd0; card2_in = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_card_on",      int'(card_on),      0);
        check("rst_busy",         int'(busy),         0);
        check("rst_done",         int'(done),         0);
        check("rst_result",       int'(result),       0);
        check("rst_player_total", int'(player_total), 0);
        check("rst_dealer_total", int'(dealer_total), 0);
        check("rst_blackjack",    int'(blackjack),    0);
        check("rst_doubled",      int'(doubled),      0);

        // Stand on 18, dealer draws 4 then 3 to 17.
        set_cards(0, 0, 0, 4, 3);
        run_round(10, 8, 4, 6, 0, 1'b0, 1'b0);
        check("t1_player_total", int'(player_total), 18);
        check("t1_dealer_total", int'(dealer_total), 17);
        check("t1_result",       int'(result),       1);
        check("t1_pulses",       pulses,             4);

        // Player natural, dealer without 21.
        set_cards(0, 0, 0, 0, 0);
        run_round(10, 1, 4, 6, 0, 1'b0, 1'b0);
        check("t2_blackjack", int'(blackjack), 1);
        check("t2_result",    int'(result),    1);
        check("t2_pulses",    pulses,          2);

        // Both naturals push.
        run_round(10, 1, 10, 1, 0, 1'b0, 1'b0);
        check("t2b_result", int'(result), 3);

        // Player busts on a hit, dealer draws nothing.
        set_cards(8, 0, 0, 0, 0);
        run_round(10, 6, 10, 7, 0, 1'b0, 1'b0);
        check("t3_player_total", int'(player_total), 24);
        check("t3_result",       int'(result),       2);
        check("t3_pulses",       pulses,             3);

        // Zero cards on the deal and on a hit force re-strobes.
        set_cards(5, 0, 0, 2, 0);
        run_round(10, 2, 9, 7, 0, 1'b1, 1'b1);
        check("t4_player_total", int'(player_total), 17);
        check("t4_pulses",       pulses,             6);

        // Start ignored mid-round; hit and stand together act as stand.
        set_cards(0, 0, 0, 0, 0);
        run_round(10, 7, 10, 8, 1, 1'b0, 1'b0);
        check("t5_result", int'(result), 2);
        check("t5_pulses", pulses,       2);

        // Dealer soft 17 stands.
        run_round(10, 9, 1, 6, 0, 1'b0, 1'b0);
        check("t6_dealer_total", int'(dealer_total), 17);
        check("t6_result",       int'(result),       1);

        // Dealer busts.
        set_cards(0, 0, 0, 10, 0);
        run_round(10, 8, 10, 6, 0, 1'b0, 1'b0);
        check("t7_dealer_total", int'(dealer_total), 26);
        check("t7_result",       int'(result),       1);

        // Hit to exactly 21 ends the player turn.
        set_cards(10, 0, 0, 0, 0);
        run_round(5, 6, 10, 7, 0, 1'b0, 1'b0);
        check("t8_player_total", int'(player_total), 21);

        // Soft hand hardens after a hit.
        set_cards(10, 0, 0, 0, 0);
        run_round(1, 5, 10, 10, 0, 1'b0, 1'b0);
        check("t9_player_total", int'(player_total), 16);
        check("t9_result",       int'(result),       2);

        // Equal totals push; several hits in one turn.
        set_cards(0, 0, 0, 0, 0);
        run_round(10, 9, 10, 9, 0, 1'b0, 1'b0);
        check("t10_result", int'(result), 3);
        set_cards(2, 3, 0, 0, 0);
        run_round(2, 3, 10, 7, 0, 1'b0, 1'b0);
        check("t11_player_total", int'(player_total), 10);

`ifdef BJ_DOUBLE_EN
        set_cards(10, 0, 0, 2, 0);
        run_round(5, 6, 10, 6, 2, 1'b0, 1'b0);
        check("t12_player_total", int'(player_total), 21);
        check("t12_doubled",      int'(doubled),      1);
        check("t12_result",       int'(result),       1);
`else
        set_cards(0, 0, 0, 0, 0);
        run_round(10, 7, 10, 7, 3, 1'b0, 1'b0);
        check("t12_doubled", int'(doubled), 0);
        check("t12_result",  int'(result),  3);
`endif

        // Reset while the dealer waits on a drawn card.
        set_cards(0, 0, 0, 5, 0);
        model(10, 6, 10, 2, 0);
        gq1.delete();
        gq2.delete();
        push_pair(10, 6);
        push_pair(10, 2);
        push_pair(5, 0);
        chk_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_player();
        check("t13_player", int'(player_total), 16);
        stand = 1'b1;
        @(negedge clk);
        stand = 1'b0;
        begin
            int n = 0;
            while (!card_on && n < 20) begin
                @(negedge clk);
                n = n + 1;
            end
            check("t13_dealer_draw", int'(card_on), 1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t13_busy",         int'(busy),         0);
        check("t13_done",         int'(done),         0);
        check("t13_result",       int'(result),       0);
        check("t13_card_on",      int'(card_on),      0);
        check("t13_player_total", int'(player_total), 0);
        reset = 1'b0;
        gq1.delete();
        gq2.delete();
        @(negedge clk);
        check("t13_idle_busy",    int'(busy),    0);
        check("t13_idle_card_on", int'(card_on), 0);

        // Normal round after the mid-round reset.
        set_cards(0, 0, 0, 0, 0);
        run_round(9, 9, 10, 8, 0, 1'b0, 1'b0);
        check("t14_result", int'(result), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
